pp_final_adder: RTL and testbench
=================================

PP_FINAL_ADDER -- requirements
Module: pp_final_adder

Interface
REQ-001 SHALL have parameter SPLIT, default 32, meaning the bit position where the addition splits between pipeline stage 1 (low bits) and stage 2 (high bits); legal range 8..56.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: a carry-save pair is presented.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts the pair this cycle.
REQ-006 SHALL have port c_in, input, 63 bits: carry vector from the partial-product compressor.
REQ-007 SHALL have port s_in, input, 64 bits: sum vector from the partial-product compressor.
REQ-008 SHALL have port out_valid, output, 1 bit: product is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accepts the product.
REQ-010 SHALL have port product, output, 64 bits: final 64-bit product.
REQ-011 SHALL have port op_count, output, 16 bits: count of products delivered.

Function
REQ-012 SHALL compute product = (s_in + {c_in, 1'b0}) mod 2^64; c_in bit k has weight 2^(k+1).
REQ-013 SHALL transfer input when in_valid && in_ready, and output when out_valid && out_ready.
REQ-014 Stage 1 SHALL add the low SPLIT bits and register: low result, carry-out, and the unadded high operand bits.
REQ-015 Stage 2 SHALL add the high operand bits plus the registered carry and register the full product.
REQ-016 Latency SHALL be 2 cycles from the input handshake to out_valid, with no backpressure.
REQ-017 Throughput SHALL be one product per cycle while out_ready is held high.
REQ-018 Each stage SHALL load when it is empty or when its contents move on in the same cycle.
REQ-019 in_ready SHALL equal !s1_valid || (!s2_valid || out_ready); it is combinational from out_ready, with no combinational path from in_valid.
REQ-020 While out_valid && !out_ready, product SHALL hold stable, and at most 2 pairs SHALL be held in flight.
REQ-021 If an input handshake and an output handshake occur in the same cycle, both SHALL complete.
REQ-022 A carry-out of bit 63 SHALL be discarded without any flag.
REQ-023 op_count SHALL increment on every output handshake and wrap from 0xFFFF to 0x0000.
REQ-024 The block SHALL never duplicate or drop a pair under any in_valid/out_ready pattern.

Reset
REQ-025 On rst assertion, regardless of clk, the block SHALL clear all stage valids, set out_valid=0 and op_count=0, and set product and the stage data registers to 0.
REQ-026 in_ready SHALL read 1 during and after reset.
REQ-027 Any pairs in flight when reset asserts SHALL be lost and never emitted.
REQ-028 The first input handshake SHALL occur no earlier than the first rising edge after rst deasserts.

Structure
REQ-029 A shared package pp_pkg SHALL hold the widths PROD_W=64, CARRY_W=63, SUM_W=64 and COUNT_W=16.
REQ-030 A single sub-module cpa_slice (parameterised width, inputs a, b, cin; outputs sum, cout) SHALL be instantiated once per stage.
REQ-031 The stage-valid and handshake logic SHALL live in pp_final_adder.

Verification
REQ-032 Basic sum: s_in=5, c_in=0, out_ready=1 -> product=5, two cycles after the handshake.
REQ-033 Carry across SPLIT: s_in=0x00000000_FFFFFFFF, c_in=0 bits except bit0=1 -> product=0x00000001_00000001.
REQ-034 Wrap-around: s_in=0xFFFFFFFF_FFFFFFFF, c_in=1 -> product=0x00000000_00000001, with no error indication.
REQ-035 Backpressure: stream 4 pairs, hold out_ready=0 for 5 cycles -> in_ready drops after 2 accepted, product stays stable, then all 4 results appear in order; op_count ends at 4.
REQ-036 Reset mid-flight: 2 pairs in flight, assert rst asynchronously -> out_valid=0 and op_count=0 at once, and neither pair is emitted afterwards.
REQ-037 Random: 10k random pairs with random in_valid/out_ready -> every product matches the REQ-012 reference model, in order.

Source files
------------

// File: rtl/pp_pkg.sv
// Shared widths and helpers for the partial-product final adder.
package pp_pkg;

    localparam int PROD_W  = 64;
    localparam int CARRY_W = 63;
    localparam int SUM_W   = 64;
    localparam int COUNT_W = 16;

    // The compressor's carry vector is one place more significant than its
    // sum vector; shift it into a full-width addend.
    function automatic logic [PROD_W-1:0] carry_operand(input logic [CARRY_W-1:0] c);
        return {c, 1'b0};
    endfunction

endpackage

// File: rtl/cpa_slice.sv
// Plain carry-propagate adder slice: {cout, sum} = a + b + cin.
module cpa_slice #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] total_s;

    // Widen by one bit so the carry-out falls out of the addition.
    always_comb begin
        total_s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    end

    assign sum  = total_s[W-1:0];
    assign cout = total_s[W];

endmodule

// File: rtl/pp_final_adder.sv
// Two-stage pipelined final adder for a carry-save product pair.
// Stage 1 adds the low SPLIT bits, stage 2 adds the high bits plus the
// stage-1 carry. Valid/ready handshakes on both sides.
module pp_final_adder
    import pp_pkg::*;
#(
    parameter int SPLIT = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CARRY_W-1:0] c_in,
    input  logic [SUM_W-1:0]   s_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PROD_W-1:0]  product,
    output logic [COUNT_W-1:0] op_count
);

    localparam int HI_W = PROD_W - SPLIT;

    // Stage 1 state
    logic              s1_valid_q, s1_valid_d;
    logic [SPLIT-1:0]  s1_lo_q;
    logic              s1_cy_q;
    logic [HI_W-1:0]   s1_hi_a_q;
    logic [HI_W-1:0]   s1_hi_b_q;

    // Stage 2 state
    logic              s2_valid_q, s2_valid_d;
    logic [PROD_W-1:0] product_q, product_d;

    logic [COUNT_W-1:0] count_q, count_d;

    // Handshake terms
    logic s2_ready_s;
    logic in_ready_s;
    logic in_fire_s;
    logic out_fire_s;
    logic s2_load_s;

    // Datapath
    logic [PROD_W-1:0] operand_b_s;
    logic [SPLIT-1:0]  lo_sum_s;
    logic              lo_cout_s;
    logic [HI_W-1:0]   hi_sum_s;
    logic              hi_cout_unused_s;   // carry out of bit 63 is discarded

    assign operand_b_s = carry_operand(c_in);

    cpa_slice #(.W(SPLIT)) u_cpa_lo (
        .a    (s_in[SPLIT-1:0]),
        .b    (operand_b_s[SPLIT-1:0]),
        .cin  (1'b0),
        .sum  (lo_sum_s),
        .cout (lo_cout_s)
    );

    cpa_slice #(.W(HI_W)) u_cpa_hi (
        .a    (s1_hi_a_q),
        .b    (s1_hi_b_q),
        .cin  (s1_cy_q),
        .sum  (hi_sum_s),
        .cout (hi_cout_unused_s)
    );

    // Handshake: a stage accepts when empty or when it drains this cycle.
    always_comb begin
        s2_ready_s = !s2_valid_q || out_ready;
        in_ready_s = !s1_valid_q || s2_ready_s;
        in_fire_s  = in_valid && in_ready_s;
        out_fire_s = s2_valid_q && out_ready;
        s2_load_s  = s2_ready_s && s1_valid_q;
    end

    // Next-state for the stage valids, the assembled product and the counter.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        count_d    = count_q;
        product_d  = {hi_sum_s, s1_lo_q};
        if (in_ready_s) begin
            s1_valid_d = in_valid;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (s2_ready_s) begin
            s2_valid_d = s1_valid_q;
        end else begin
            s2_valid_d = s2_valid_q;
        end
        if (out_fire_s) begin
            count_d = count_q + 16'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Stage valid bits and delivered-product counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            count_q    <= 16'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            count_q    <= count_d;
        end
    end

    // Stage 1 data: low partial sum, its carry, and the untouched high operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_lo_q   <= '0;
            s1_cy_q   <= 1'b0;
            s1_hi_a_q <= '0;
            s1_hi_b_q <= '0;
        end else if (in_fire_s) begin
            s1_lo_q   <= lo_sum_s;
            s1_cy_q   <= lo_cout_s;
            s1_hi_a_q <= s_in[PROD_W-1:SPLIT];
            s1_hi_b_q <= operand_b_s[PROD_W-1:SPLIT];
        end
    end

    // Stage 2 data: the finished product, held while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            product_q <= 64'd0;
        end else if (s2_load_s) begin
            product_q <= product_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = s2_valid_q;
    assign product   = product_q;
    assign op_count  = count_q;

endmodule

// File: tb/tb_pp_final_adder.sv
// Directed and random bench for pp_final_adder with an in-order scoreboard.
module tb_pp_final_adder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [62:0] c_in;
    logic [63:0] s_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;
    logic [15:0] op_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] sb_q[$];
    logic [15:0] exp_count = 16'd0;
    logic        last_in_fire;
    logic        last_out_fire;

    logic [63:0] bp_s[4]   = '{64'd1, 64'd2, 64'd3, 64'd4};
    logic [62:0] bp_c[4]   = '{63'd0, 63'd1, 63'd2, 63'd3};
    logic [63:0] bp_exp[4] = '{64'd1, 64'd4, 64'd7, 64'd10};

    pp_final_adder #(.SPLIT(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .c_in      (c_in),
        .s_in      (s_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_prod(input logic [62:0] c, input logic [63:0] s);
        logic [63:0] cw;
        cw = {c, 1'b0};
        return s + cw;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at the falling edge, observe just after, track handshakes.
    task automatic drive(input logic v, input logic [62:0] c, input logic [63:0] s, input logic ordy);
        @(negedge clk);
        in_valid  = v;
        c_in      = c;
        s_in      = s;
        out_ready = ordy;
        #1;
        check_eq("op_count", {48'd0, op_count}, {48'd0, exp_count});
        last_in_fire  = in_valid && in_ready;
        last_out_fire = out_valid && out_ready;
        if (last_in_fire) sb_q.push_back(ref_prod(c, s));
        if (last_out_fire) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow: got product 0x%016h expected no output", product);
            end else begin
                check_eq("sb_product", product, sb_q.pop_front());
            end
            exp_count = exp_count + 16'd1;
        end
    endtask

    task automatic one_shot(input string tag, input logic [62:0] c, input logic [63:0] s,
                            input logic [63:0] exp);
        drive(1'b1, c, s, 1'b1);
        check_eq({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        drive(1'b0, 63'd0, 64'd0, 1'b1);
        check_eq({tag, "_valid_c1"}, {63'd0, out_valid}, 64'd0);
        drive(1'b0, 63'd0, 64'd0, 1'b1);
        check_eq({tag, "_valid_c2"}, {63'd0, out_valid}, 64'd1);
        check_eq({tag, "_product"}, product, exp);
        drive(1'b0, 63'd0, 64'd0, 1'b1);
    endtask

    initial begin
        int acc;
        int got;
        int first_block;
        logic [63:0] held;
        logic held_v;
        logic ordy;

        rst = 1'b1; in_valid = 1'b0; c_in = 63'd0; s_in = 64'd0; out_ready = 1'b0;
        #3;
        check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("rst_op_count", {48'd0, op_count}, 64'd0);
        check_eq("rst_product", product, 64'd0);
        check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        one_shot("basic", 63'd0, 64'd5, 64'd5);
        one_shot("split_carry", 63'd1, 64'h00000000_FFFFFFFF, 64'h00000001_00000001);
        one_shot("wrap", 63'd1, 64'hFFFFFFFF_FFFFFFFF, 64'h00000000_00000001);
        one_shot("carry_ones", {63{1'b1}}, 64'd0, 64'hFFFFFFFF_FFFFFFFE);

        // Backpressure: out_ready low for the first 5 cycles.
        acc = 0; got = 0; first_block = -1; held = 64'd0; held_v = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            ordy = (cyc >= 5);
            if (acc < 4) drive(1'b1, bp_c[acc], bp_s[acc], ordy);
            else         drive(1'b0, 63'd0, 64'd0, ordy);
            if (!in_ready && acc < 4 && first_block < 0) first_block = acc;
            if (out_valid && !ordy) begin
                if (!held_v) begin
                    held = product;
                    held_v = 1'b1;
                end else begin
                    check_eq("bp_hold", product, held);
                end
            end
            if (last_out_fire) begin
                check_eq("bp_order", product, bp_exp[got]);
                got++;
            end
            if (last_in_fire) acc++;
        end
        check_eq("bp_first_block", 64'(first_block), 64'd2);
        check_eq("bp_got", 64'(got), 64'd4);
        drive(1'b0, 63'd0, 64'd0, 1'b1);
        check_eq("bp_op_count", {48'd0, op_count}, 64'd8);

        // Reset with two pairs in flight.
        drive(1'b1, 63'd7, 64'd100, 1'b0);
        drive(1'b1, 63'd9, 64'd200, 1'b0);
        drive(1'b0, 63'd0, 64'd0, 1'b0);
        check_eq("mid_pre_valid", {63'd0, out_valid}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("mid_op_count", {48'd0, op_count}, 64'd0);
        check_eq("mid_product", product, 64'd0);
        check_eq("mid_in_ready", {63'd0, in_ready}, 64'd1);
        sb_q.delete();
        exp_count = 16'd0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 63'd0, 64'd0, 1'b1);
            check_eq("mid_no_emit", {63'd0, out_valid}, 64'd0);
        end

        // Random traffic with random stalls.
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 3) != 0),
                  {$urandom(), $urandom()} >> 1,
                  {$urandom(), $urandom()},
                  1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) begin
            drive(1'b0, 63'd0, 64'd0, 1'b1);
        end
        check_eq("drain_empty", 64'(sb_q.size()), 64'd0);
        drive(1'b0, 63'd0, 64'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
